// File: rtl/enemy_sprite_render.sv
// Enemy sprite pixel pipeline: per-frame position latch, box test,
// sync ROM addressing, transparency and hit-flash blanking.
module enemy_sprite_render #(
  parameter logic [10:0] HALF_W = 11'd64,
  parameter logic [10:0] HALF_H = 11'd64,
  parameter int COLOR_W = 12,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
  parameter logic [5:0] FLASH_FRAMES = 6'd32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_neg,
  input  logic [10:0]        enemy_x,
  input  logic [10:0]        enemy_y,
  input  logic [10:0]        h_cnt,
  input  logic [10:0]        v_cnt,
  input  logic               de,
  input  logic               hit,
  output logic [13:0]        rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               sprite_on,
  output logic [COLOR_W-1:0] sprite_rgb,
  output logic               de_out
);

  typedef enum logic {IDLE, FLASH} state_t;

  state_t      state;
  logic [5:0]  flash_cnt;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        blank;

  logic signed [12:0] hx;
  logic signed [12:0] vy;
  logic signed [12:0] lo_x;
  logic signed [12:0] hi_x;
  logic signed [12:0] lo_y;
  logic signed [12:0] hi_y;
  logic               in_box;
  logic [6:0]         dx;
  logic [6:0]         dy;

  logic               s1_vis;
  logic               s1_de;
  logic               s2_vis;
  logic               s2_de;
  logic               on_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x <= HALF_W;
      pos_y <= HALF_H;
    end else if (vs_neg) begin
      pos_x <= enemy_x;
      pos_y <= enemy_y;
    end
  end

  // hit has priority over the frame decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flash_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state     <= FLASH;
            flash_cnt <= FLASH_FRAMES;
          end
        end
        FLASH: begin
          if (hit) begin
            flash_cnt <= FLASH_FRAMES;
          end else if (vs_neg) begin
            if (flash_cnt == 6'd1) begin
              state     <= IDLE;
              flash_cnt <= '0;
            end else begin
              flash_cnt <= flash_cnt - 6'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          flash_cnt <= '0;
        end
      endcase
    end
  end

  assign blank = (state == FLASH) & flash_cnt[2];

  // widened signed bounds so off-screen edges never wrap
  assign hx   = $signed({2'b00, h_cnt});
  assign vy   = $signed({2'b00, v_cnt});
  assign lo_x = $signed({2'b00, pos_x}) - $signed({2'b00, HALF_W});
  assign hi_x = $signed({2'b00, pos_x}) + $signed({2'b00, HALF_W});
  assign lo_y = $signed({2'b00, pos_y}) - $signed({2'b00, HALF_H});
  assign hi_y = $signed({2'b00, pos_y}) + $signed({2'b00, HALF_H});

  assign in_box = de & (hx >= lo_x) & (hx < hi_x)
                & (vy >= lo_y) & (vy < hi_y);

  assign dx = h_cnt[6:0] - lo_x[6:0];
  assign dy = v_cnt[6:0] - lo_y[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      s1_vis   <= 1'b0;
      s1_de    <= 1'b0;
    end else begin
      if (in_box) begin
        rom_addr <= {dy, dx};
      end
      s1_vis <= in_box & ~blank;
      s1_de  <= de;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vis <= 1'b0;
      s2_de  <= 1'b0;
    end else begin
      s2_vis <= s1_vis;
      s2_de  <= s1_de;
    end
  end

  assign on_next = s2_vis & (rom_data != TRANSPARENT);

  always_ff @(posedge clk) begin
    if (rst) begin
      sprite_on  <= 1'b0;
      sprite_rgb <= '0;
      de_out     <= 1'b0;
    end else begin
      sprite_on  <= on_next;
      sprite_rgb <= on_next ? rom_data : '0;
      de_out     <= s2_de;
    end
  end

endmodule

// File: tb/tb_enemy_sprite_render.sv
// Bench for enemy_sprite_render: behavioural model plus directed
// probes with hand-computed addresses, colours and flash pattern.
module tb_enemy_sprite_render;

  logic        clk;
  logic        rst;
  logic        vs_neg;
  logic [10:0] enemy_x;
  logic [10:0] enemy_y;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        de;
  logic        hit;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;
  logic        sprite_on;
  logic [11:0] sprite_rgb;
  logic        de_out;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  bit chk_en = 0;

  enemy_sprite_render dut (
    .clk(clk), .rst(rst), .vs_neg(vs_neg),
    .enemy_x(enemy_x), .enemy_y(enemy_y),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .de(de), .hit(hit),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sprite_on(sprite_on), .sprite_rgb(sprite_rgb),
    .de_out(de_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] rom_fn(input int a, input int m);
    logic [13:0] aa;
    aa = a[13:0];
    case (m)
      0: return 12'hF00;
      1: return 12'h000;
      default: return (aa[3:0] == 4'd0) ? 12'h000 : aa[11:0];
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr), mode);

  // behavioural model: spec rules in plain integer arithmetic
  int m_px, m_py, m_cnt, e_addr;
  int s1v, s1d, s2v, s2d, s2a;
  int e_on, e_rgb, e_de;

  always @(posedge clk) begin
    int lx, ly, hh, vv, ib, bl, c;
    if (rst) begin
      m_px = 64; m_py = 64; m_cnt = 0; e_addr = 0;
      s1v = 0; s1d = 0; s2v = 0; s2d = 0; s2a = 0;
      e_on = 0; e_rgb = 0; e_de = 0;
    end else begin
      hh = int'(h_cnt);
      vv = int'(v_cnt);
      lx = m_px - 64;
      ly = m_py - 64;
      ib = (de && hh >= lx && hh < m_px + 64
            && vv >= ly && vv < m_py + 64) ? 1 : 0;
      bl = (m_cnt > 0 && ((m_cnt / 4) % 2 == 1)) ? 1 : 0;
      c = int'(rom_fn(s2a, mode));
      e_on = (s2v != 0 && c != 0) ? 1 : 0;
      e_rgb = e_on ? c : 0;
      e_de = s2d;
      s2v = s1v; s2d = s1d; s2a = e_addr;
      if (ib != 0) e_addr = (vv - ly) * 128 + (hh - lx);
      s1v = (ib != 0 && bl == 0) ? 1 : 0;
      s1d = de ? 1 : 0;
      if (hit) m_cnt = 32;
      else if (vs_neg && m_cnt > 0) m_cnt = m_cnt - 1;
      if (vs_neg) begin
        m_px = int'(enemy_x);
        m_py = int'(enemy_y);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_on", {31'd0, sprite_on}, e_on);
      chk("m_rgb", {20'd0, sprite_rgb}, e_rgb);
      chk("m_de", {31'd0, de_out}, e_de);
      chk("m_addr", {18'd0, rom_addr}, e_addr);
    end
  end

  task automatic probe(input int h, input int v, input int ea,
                       input int eo, input int er);
    h_cnt = h[10:0]; v_cnt = v[10:0]; de = 1;
    @(negedge clk);
    chk("p_addr", {18'd0, rom_addr}, ea);
    de = 0;
    @(negedge clk);
    @(negedge clk);
    chk("p_on", {31'd0, sprite_on}, eo);
    chk("p_rgb", {20'd0, sprite_rgb}, er);
    chk("p_de_out", {31'd0, de_out}, 1);
  endtask

  task automatic frame(input int x, input int y);
    enemy_x = x[10:0]; enemy_y = y[10:0];
    de = 0; vs_neg = 1;
    @(negedge clk);
    vs_neg = 0;
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      h_cnt = h[10:0]; v_cnt = v[10:0];
      de = ((h % 7) != 3);
      @(negedge clk);
    end
    de = 0;
    repeat (3) @(negedge clk);
  endtask

  int blank_pat[10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};

  initial begin
    int vis;
    rst = 1; vs_neg = 0; hit = 0; de = 1;
    enemy_x = 11'd0; enemy_y = 11'd0;
    h_cnt = 11'd0; v_cnt = 11'd0;
    @(negedge clk);
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_on", {31'd0, sprite_on}, 0);
    chk("rst_de", {31'd0, de_out}, 0);
    chk("rst_addr", {18'd0, rom_addr}, 0);
    rst = 0; de = 0;
    @(negedge clk);

    probe(0, 0, 0, 1, 12'hF00);

    // reset asserted mid-line
    for (int h = 0; h < 20; h++) begin
      h_cnt = h[10:0]; v_cnt = 11'd5; de = 1;
      rst = (h == 8 || h == 9);
      @(negedge clk);
      if (h == 9) begin
        chk("midrst_on", {31'd0, sprite_on}, 0);
        chk("midrst_rgb", {20'd0, sprite_rgb}, 0);
        chk("midrst_de", {31'd0, de_out}, 0);
      end
    end
    rst = 0; de = 0;
    repeat (3) @(negedge clk);

    frame(300, 200);
    enemy_x = 11'd500;
    probe(236, 136, 0, 1, 12'hF00);
    probe(363, 136, 127, 1, 12'hF00);
    probe(236, 263, 16256, 1, 12'hF00);
    probe(363, 263, 16383, 1, 12'hF00);
    probe(364, 200, 16383, 0, 0);
    probe(235, 200, 16383, 0, 0);
    probe(300, 264, 16383, 0, 0);
    mode = 1;
    probe(300, 200, 8256, 0, 0);
    mode = 2;
    line(136, 228, 372);
    line(263, 228, 372);
    line(264, 228, 260);
    mode = 0;

    frame(10, 200);
    probe(0, 200, 8246, 1, 12'hF00);
    probe(73, 200, 8319, 1, 12'hF00);
    probe(74, 200, 8319, 0, 0);
    probe(1023, 200, 8319, 0, 0);
    mode = 2;
    line(200, 1000, 1023);
    line(200, 0, 80);
    mode = 0;

    // hit then full 32-frame flash
    frame(300, 200);
    hit = 1;
    @(negedge clk);
    hit = 0;
    for (int k = 0; k < 34; k++) begin
      if (k < 10) vis = 1 - blank_pat[k];
      else if (k >= 32) vis = 1;
      else vis = (((32 - k) / 4) % 2 == 1) ? 0 : 1;
      probe(300, 200, 8256, vis, vis ? 12'hF00 : 0);
      frame(300, 200);
    end

    // re-hit during frame 10
    hit = 1;
    @(negedge clk);
    hit = 0;
    for (int k = 0; k < 10; k++) frame(300, 200);
    probe(300, 200, 8256, 0, 0);
    hit = 1;
    @(negedge clk);
    hit = 0;
    probe(300, 200, 8256, 1, 12'hF00);
    frame(300, 200);
    probe(300, 200, 8256, 0, 0);
    frame(300, 200);

    // hit coincident with vs_neg: reload wins, position still latches
    hit = 1; vs_neg = 1; enemy_x = 11'd310; enemy_y = 11'd200;
    @(negedge clk);
    hit = 0; vs_neg = 0;
    probe(246, 200, 8192, 1, 12'hF00);
    frame(310, 200);
    probe(246, 200, 8192, 0, 0);

    // reset during flash
    rst = 1;
    @(negedge clk);
    rst = 0;
    probe(0, 0, 0, 1, 12'hF00);
    probe(127, 127, 16383, 1, 12'hF00);

    repeat (4) @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
